clk_div_prog: RTL and testbench

Parametrised, runtime-programmable clock divider that generates a registered divided clock `clko` and a one-cycle `tick` enable, both derived from `clk`.
- Divide ratio is loaded at runtime.
- A new ratio takes effect only on a period boundary, so no output period is ever truncated or stretched.
- Sits between the system clock and slow peripherals (blinkers, UART baud, scan timers) as a single-clock-domain source.

---
 rtl/clk_div_prog.sv | 71 +++++++
 tb/tb_clk_div_prog.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: registered divided clock plus one-cycle tick.
// A newly loaded ratio is held pending and swapped in only when a period wraps.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clko,
    output logic             tick,
    output logic [WIDTH-1:0] div_cur,
    output logic             div_busy,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] half;
    logic             at_end;
    logic             load_ok;

    always_comb begin
        at_end   = (cnt == div_cur - ONE);
        half     = div_cur >> 1;
        load_ok  = div_load && (div_in >= TWO);
        cnt_next = cnt;
        if (en) begin
            cnt_next = at_end ? '0 : cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            clko     <= 1'b0;
            tick     <= 1'b0;
            div_cur  <= DIV_RST;
            pending  <= '0;
            div_busy <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            // At a wrap cnt_next is 0, which is below half for any legal N, so clko falls
            if (en) begin
                cnt  <= cnt_next;
                clko <= (cnt_next >= half);
            end
            tick <= en && at_end;
            if (en && at_end && div_busy) begin
                div_cur  <= pending;
                div_busy <= 1'b0;
            end
            // A load in the same cycle as an apply overrides the clear above
            if (load_ok) begin
                pending  <= div_in;
                div_busy <= 1'b1;
            end
            if (div_load && !load_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus randomized traffic, all checked
// against a period-position model of the divider.
module tb_clk_div_prog;

    localparam int WIDTH = 8;
    localparam int DEF   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             clko;
    logic             tick;
    logic [WIDTH-1:0] div_cur;
    logic             div_busy;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;

    // Model: position within the current period, the period length, and load state
    int m_pos, m_n, m_pend;
    bit m_busy, m_err, m_tick, m_clko;

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clko     (clko),
        .tick     (tick),
        .div_cur  (div_cur),
        .div_busy (div_busy),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit e, input bit ld, input int d, input bit r);
        bit wrap;
        if (!r) begin
            m_pos = 0; m_n = DEF; m_pend = 0;
            m_busy = 0; m_err = 0; m_tick = 0;
        end else begin
            wrap = e && (m_pos == m_n - 1);
            if (e) m_pos = wrap ? 0 : m_pos + 1;
            m_tick = wrap;
            if (wrap && m_busy) begin
                m_n = m_pend;
                m_busy = 0;
            end
            if (ld) begin
                if (d >= 2) begin
                    m_pend = d;
                    m_busy = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        m_clko = (m_pos >= m_n / 2);
    endtask

    function automatic logic [11:0] exp_vec();
        return {m_clko, m_tick, 8'(m_n), m_busy, m_err};
    endfunction

    task automatic cyc(input bit e, input bit ld, input int d, input bit r);
        en = e; div_load = ld; div_in = 8'(d); rst_n = r;
        @(posedge clk);
        model_step(e, ld, d, r);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        if ({clko, tick, div_cur, div_busy, cfg_err} !== 12'b0_0_00000100_0_0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", {clko, tick, div_cur, div_busy, cfg_err}, 12'b0_0_00000100_0_0);
        end
        checks++;
    endtask

    task automatic test_default();
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 1);
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL default_div cyc%0d got %h exp %h", i, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_freeze();
        int guard;
        cyc(0, 0, 0, 0);
        guard = 0;
        while (m_pos != 2 && guard < 20) begin
            cyc(1, 0, 0, 1);
            guard++;
        end
        if (guard >= 20) begin
            errors++;
            $display("FAIL freeze_setup got guard %0d exp below 20", guard);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            if ({clko, tick} !== 2'b10) begin
                errors++;
                $display("FAIL freeze_hold cyc%0d got clko=%b tick=%b exp clko=1 tick=0", i, clko, tick);
            end
            checks++;
        end
        cyc(1, 0, 0, 1);
        if ({clko, tick} !== 2'b10) begin
            errors++;
            $display("FAIL freeze_resume3 got clko=%b tick=%b exp clko=1 tick=0", clko, tick);
        end
        checks++;
        cyc(1, 0, 0, 1);
        if ({clko, tick} !== 2'b01) begin
            errors++;
            $display("FAIL freeze_wrap got clko=%b tick=%b exp clko=0 tick=1", clko, tick);
        end
        checks++;
    endtask

    task automatic test_load5();
        cyc(1, 0, 0, 1);
        cyc(1, 1, 5, 1);
        if (div_busy !== 1'b1 || div_cur !== 8'd4) begin
            errors++;
            $display("FAIL load5_pending got busy=%b div=%0d exp busy=1 div=4", div_busy, div_cur);
        end
        checks++;
        for (int i = 0; i < 14; i++) begin
            cyc(1, 0, 0, 1);
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL load5 cyc%0d got %h exp %h", i, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_last_wins();
        cyc(1, 1, 2, 1);
        cyc(1, 1, 7, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 1);
            if (div_cur == 8'd2) begin
                errors++;
                $display("FAIL last_wins_interm cyc%0d got div=2 exp never 2", i);
            end
            checks++;
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL last_wins cyc%0d got %h exp %h", i, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_illegal();
        cyc(1, 1, 1, 1);
        cyc(1, 1, 0, 1);
        if (cfg_err !== 1'b1 || div_busy !== 1'b0 || div_cur !== 8'd7) begin
            errors++;
            $display("FAIL illegal_load got err=%b busy=%b div=%0d exp err=1 busy=0 div=7", cfg_err, div_busy, div_cur);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 1);
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL illegal cyc%0d got %h exp %h", i, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_reset_pending();
        cyc(1, 1, 9, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        if ({clko, tick, div_cur, div_busy, cfg_err} !== 12'b0_0_00000100_0_0) begin
            errors++;
            $display("FAIL reset_pending got %h exp %h", {clko, tick, div_cur, div_busy, cfg_err}, 12'b0_0_00000100_0_0);
        end
        checks++;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 1);
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_pending cyc%0d got %h exp %h", i, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_max();
        int k, lows, highs;
        cyc(1, 1, 255, 1);
        k = 0;
        while (!tick && k < 600) begin
            cyc(1, 0, 0, 1);
            k++;
        end
        if (!tick || div_cur !== 8'd255) begin
            errors++;
            $display("FAIL max_apply got tick=%b div=%0d exp tick=1 div=255", tick, div_cur);
        end
        checks++;
        k = 0; lows = 0; highs = 0;
        do begin
            cyc(1, 0, 0, 1);
            k++;
            if (clko) highs++; else lows++;
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL max cyc%0d got %h exp %h", k, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end while (!tick && k < 600);
        if (k != 255 || lows != 127 || highs != 128) begin
            errors++;
            $display("FAIL max_period got len=%0d low=%0d high=%0d exp len=255 low=127 high=128", k, lows, highs);
        end
        checks++;
    endtask

    task automatic test_random();
        bit e, ld, r;
        int d;
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom % 4) != 0;
            ld = ($urandom % 8) == 0;
            d  = $urandom % 10;
            r  = ($urandom % 200) != 0;
            cyc(e, ld, d, r);
            if ({clko, tick, div_cur, div_busy, cfg_err} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got %h exp %h", i, {clko, tick, div_cur, div_busy, cfg_err}, exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_freeze();
        test_load5();
        test_last_wins();
        test_illegal();
        test_reset_pending();
        test_max();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
